// File: rtl/operand_fetch.sv
// ID->EX operand stage: regfile read, EX/MEM forwarding, load-use bubble
// and the ID/EX pipeline register with a valid/ready handshake.
module operand_fetch #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_rd_wren,
    input  logic             id_is_load,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_rd_wren,
    input  logic [XLEN-1:0]  mem_rd_data,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [4:0]       ex_rd_addr,
    output logic             ex_rd_wren,
    output logic             ex_is_load,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q,      ex_pc_d;
    logic [XLEN-1:0]  ex_rs1_val_q, ex_rs1_val_d;
    logic [XLEN-1:0]  ex_rs2_val_q, ex_rs2_val_d;
    logic [4:0]       ex_rd_addr_q, ex_rd_addr_d;
    logic             ex_rd_wren_q, ex_rd_wren_d;
    logic             ex_is_load_q, ex_is_load_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

    logic             ex_fwd_ok;
    logic             hazard;
    logic [XLEN-1:0]  src1_val, src2_val;

    assign rs1_addr = id_rs1_addr;
    assign rs2_addr = id_rs2_addr;

    // A load in EX has no result yet, so it can never forward from EX.
    assign ex_fwd_ok = ex_valid_q && ex_rd_wren_q && !ex_is_load_q;

    always_comb begin
        src1_val = rs1_data;
        if (id_rs1_addr == 5'd0)
            src1_val = '0;
        else if (ex_fwd_ok && ex_rd_addr_q == id_rs1_addr)
            src1_val = ex_alu_result;
        else if (mem_rd_wren && mem_rd_addr == id_rs1_addr)
            src1_val = mem_rd_data;
    end

    always_comb begin
        src2_val = rs2_data;
        if (id_rs2_addr == 5'd0)
            src2_val = '0;
        else if (ex_fwd_ok && ex_rd_addr_q == id_rs2_addr)
            src2_val = ex_alu_result;
        else if (mem_rd_wren && mem_rd_addr == id_rs2_addr)
            src2_val = mem_rd_data;
    end

    // Both sources are compared regardless of whether the opcode uses them.
    assign hazard = id_valid && ex_valid_q && ex_is_load_q && ex_rd_wren_q
                    && (ex_rd_addr_q != 5'd0)
                    && (ex_rd_addr_q == id_rs1_addr || ex_rd_addr_q == id_rs2_addr);

    assign id_ready = !hazard && (!ex_valid_q || ex_ready);

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_rs1_val_d = ex_rs1_val_q;
        ex_rs2_val_d = ex_rs2_val_q;
        ex_rd_addr_d = ex_rd_addr_q;
        ex_rd_wren_d = ex_rd_wren_q;
        ex_is_load_d = ex_is_load_q;
        stall_cnt_d  = stall_cnt_q;

        if (hazard && !flush && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (ex_valid_q && !ex_ready) begin
            ex_valid_d = 1'b1;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = id_valid;
            if (id_valid) begin
                ex_pc_d      = id_pc;
                ex_rs1_val_d = src1_val;
                ex_rs2_val_d = src2_val;
                ex_rd_addr_d = id_rd_addr;
                ex_rd_wren_d = id_rd_wren;
                ex_is_load_d = id_is_load;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_rd_addr_q <= '0;
            ex_rd_wren_q <= 1'b0;
            ex_is_load_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs1_val_q <= ex_rs1_val_d;
            ex_rs2_val_q <= ex_rs2_val_d;
            ex_rd_addr_q <= ex_rd_addr_d;
            ex_rd_wren_q <= ex_rd_wren_d;
            ex_is_load_q <= ex_is_load_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rs1_val = ex_rs1_val_q;
    assign ex_rs2_val = ex_rs2_val_q;
    assign ex_rd_addr = ex_rd_addr_q;
    assign ex_rd_wren = ex_rd_wren_q;
    assign ex_is_load = ex_is_load_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, stall saturation and
// async reset sequences, then random traffic against a behavioural model.
module tb_operand_fetch;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             id_valid, id_ready;
    logic [XLEN-1:0]  id_pc;
    logic [4:0]       id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic             id_rd_wren, id_is_load;
    logic [4:0]       rs1_addr, rs2_addr;
    logic [XLEN-1:0]  rs1_data, rs2_data, ex_alu_result;
    logic [4:0]       mem_rd_addr;
    logic             mem_rd_wren;
    logic [XLEN-1:0]  mem_rd_data;
    logic             ex_ready, flush;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_val, ex_rs2_val;
    logic [4:0]       ex_rd_addr;
    logic             ex_rd_wren, ex_is_load;
    logic [CNT_W-1:0] stall_cnt;

    operand_fetch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_rd_wren(id_rd_wren), .id_is_load(id_is_load),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_alu_result(ex_alu_result),
        .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren), .mem_rd_data(mem_rd_data),
        .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd_addr(ex_rd_addr), .ex_rd_wren(ex_rd_wren), .ex_is_load(ex_is_load),
        .stall_cnt(stall_cnt)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what EX should be holding, derived from the stage rules.
    logic            m_valid, m_wren, m_load;
    logic [31:0]     m_pc, m_rs1, m_rs2;
    logic [4:0]      m_rd;
    int              m_cnt;

    task automatic model_reset();
        m_valid = 0; m_wren = 0; m_load = 0;
        m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] s, input logic [31:0] rf);
        if (s == 0) return 0;
        if (m_valid && m_wren && !m_load && m_rd == s) return ex_alu_result;
        if (mem_rd_wren && mem_rd_addr == s) return mem_rd_data;
        return rf;
    endfunction

    function automatic bit m_hazard();
        return id_valid && m_valid && m_load && m_wren && m_rd != 0 &&
               (m_rd == id_rs1_addr || m_rd == id_rs2_addr);
    endfunction

    function automatic bit m_ready();
        return !m_hazard() && (!m_valid || ex_ready);
    endfunction

    task automatic model_clk();
        bit hz;
        logic [31:0] f1, f2;
        hz = m_hazard();
        f1 = m_fwd(id_rs1_addr, rs1_data);
        f2 = m_fwd(id_rs2_addr, rs2_data);
        if (hz && !flush && m_cnt < int'(CNT_MAX)) m_cnt++;
        if (flush) m_valid = 0;
        else if (m_valid && !ex_ready) m_valid = 1;
        else if (hz) m_valid = 0;
        else begin
            m_valid = id_valid;
            if (id_valid) begin
                m_pc = id_pc; m_rs1 = f1; m_rs2 = f2;
                m_rd = id_rd_addr; m_wren = id_rd_wren; m_load = id_is_load;
            end
        end
    endtask

    typedef struct {
        logic iv; logic [31:0] pc; logic [4:0] r1, r2, rd; logic wr, ld;
        logic [31:0] d1, d2, alu; logic [4:0] mrd; logic mwr; logic [31:0] md;
        logic rdy, fl;
        logic e_rdy, e_vld; logic [31:0] e1, e2; logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic drive(input vec_t v);
        id_valid = v.iv; id_pc = v.pc; id_rs1_addr = v.r1; id_rs2_addr = v.r2;
        id_rd_addr = v.rd; id_rd_wren = v.wr; id_is_load = v.ld;
        rs1_data = v.d1; rs2_data = v.d2; ex_alu_result = v.alu;
        mem_rd_addr = v.mrd; mem_rd_wren = v.mwr; mem_rd_data = v.md;
        ex_ready = v.rdy; flush = v.fl;
    endtask

    // One cycle with model-based checks on both sides of the edge.
    task automatic tick_model();
        #2;
        chk("id_ready", {31'b0, id_ready}, {31'b0, m_ready()});
        chk("rs_addr", {22'b0, rs1_addr, rs2_addr}, {22'b0, id_rs1_addr, id_rs2_addr});
        @(posedge clk_i);
        model_clk();
        #1;
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        chk("stall_cnt", {28'b0, stall_cnt}, m_cnt);
        if (m_valid) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rs1_val", ex_rs1_val, m_rs1);
            chk("ex_rs2_val", ex_rs2_val, m_rs2);
            chk("ex_ctrl", {25'b0, ex_rd_addr, ex_rd_wren, ex_is_load},
                {25'b0, m_rd, m_wren, m_load});
        end
    endtask

    vec_t v;

    initial begin
        //          iv pc        r1 r2 rd wr ld d1       d2       alu       mrd mwr md       rdy fl | rdy vld e1        e2       cnt
        tbl[0]  = '{1, 32'h100, 1, 2, 3, 1, 0, 32'h11, 32'h22,  32'h0,    0, 0, 32'h0,    1, 0,   1, 1, 32'h11,   32'h22,   0};
        tbl[1]  = '{1, 32'h104, 3, 0, 5, 1, 1, 32'h33, 32'h77,  32'hAAAA, 3, 1, 32'hBBBB, 1, 0,   1, 1, 32'hAAAA, 32'h0,    0};
        tbl[2]  = '{1, 32'h108, 1, 5, 6, 1, 0, 32'h11, 32'h55,  32'h0,    3, 1, 32'hBBBB, 1, 0,   0, 0, 32'h0,    32'h0,    1};
        tbl[3]  = '{1, 32'h108, 1, 5, 6, 1, 0, 32'h11, 32'h55,  32'h0,    5, 1, 32'h1234, 1, 0,   1, 1, 32'h11,   32'h1234, 1};
        tbl[4]  = '{1, 32'h10c, 3, 0, 0, 1, 0, 32'h33, 32'h0,   32'h0,    3, 1, 32'hBBBB, 1, 0,   1, 1, 32'hBBBB, 32'h0,    1};
        tbl[5]  = '{1, 32'h110, 0, 2, 8, 1, 1, 32'h99, 32'h22,  32'hFFFF, 0, 1, 32'hFFFF, 1, 0,   1, 1, 32'h0,    32'h22,   1};
        tbl[6]  = '{1, 32'h114, 8, 1, 9, 1, 0, 32'h88, 32'h11,  32'h0,    0, 0, 32'h0,    1, 1,   0, 0, 32'h0,    32'h0,    1};
        tbl[7]  = '{1, 32'h118, 1, 2, 9, 1, 0, 32'h11, 32'h22,  32'h0,    0, 0, 32'h0,    0, 0,   1, 1, 32'h11,   32'h22,   1};
        tbl[8]  = '{1, 32'h11c, 4, 2, 10,1, 0, 32'h44, 32'h2222,32'h0,    0, 0, 32'h0,    0, 0,   0, 1, 32'h11,   32'h22,   1};
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = '{1, 32'h11c, 4, 2, 10,1, 0, 32'h44, 32'h2222,32'h0,    0, 0, 32'h0,    1, 0,   1, 1, 32'h44,   32'h2222, 1};
        tbl[12] = '{0, 32'h0,   0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0,    0, 0, 32'h0,    1, 0,   1, 0, 32'h0,    32'h0,    1};

        rst_ni = 0;
        v = tbl[12];
        drive(v);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ex_valid", {31'b0, ex_valid}, 0);
        chk("rst_stall_cnt", {28'b0, stall_cnt}, 0);
        chk("rst_ex_data", ex_pc | ex_rs1_val | ex_rs2_val, 0);
        #6 rst_ni = 1;
        @(posedge clk_i); #1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            #2;
            chk($sformatf("tbl%0d_id_ready", i), {31'b0, id_ready}, {31'b0, tbl[i].e_rdy});
            @(posedge clk_i);
            model_clk();
            #1;
            chk($sformatf("tbl%0d_ex_valid", i), {31'b0, ex_valid}, {31'b0, tbl[i].e_vld});
            chk($sformatf("tbl%0d_stall_cnt", i), {28'b0, stall_cnt}, {28'b0, tbl[i].e_cnt});
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_rs1", i), ex_rs1_val, tbl[i].e1);
                chk($sformatf("tbl%0d_rs2", i), ex_rs2_val, tbl[i].e2);
            end
        end

        // Load held in EX under back-pressure: stall counter saturates.
        v = tbl[12];
        v.iv = 1; v.pc = 32'h200; v.rd = 10; v.wr = 1; v.ld = 1;
        drive(v);
        @(posedge clk_i); model_clk(); #1;
        v.pc = 32'h204; v.r1 = 10; v.ld = 0; v.rdy = 0;
        drive(v);
        repeat (20) begin @(posedge clk_i); model_clk(); #1; end
        chk("sat_stall_cnt", {28'b0, stall_cnt}, {28'b0, CNT_MAX});
        chk("sat_ex_pc", ex_pc, 32'h200);
        chk("sat_id_ready", {31'b0, id_ready}, 0);
        ex_ready = 1;
        @(posedge clk_i); model_clk(); #1;
        chk("sat_bubble", {31'b0, ex_valid}, 0);
        chk("sat_hold_cnt", {28'b0, stall_cnt}, {28'b0, CNT_MAX});

        // Random traffic against the model, with an async reset midway.
        for (int c = 0; c < 400; c++) begin
            if (c == 150) begin
                #2 rst_ni = 0;
                #1;
                chk("async_ex_valid", {31'b0, ex_valid}, 0);
                chk("async_stall_cnt", {28'b0, stall_cnt}, 0);
                model_reset();
                @(posedge clk_i); #1;
                rst_ni = 1;
            end
            id_valid      = ($urandom_range(0, 9) < 8);
            id_pc         = $urandom;
            id_rs1_addr   = 5'($urandom_range(0, 7));
            id_rs2_addr   = 5'($urandom_range(0, 7));
            id_rd_addr    = 5'($urandom_range(0, 7));
            id_rd_wren    = ($urandom_range(0, 3) != 0);
            id_is_load    = ($urandom_range(0, 2) == 0);
            rs1_data      = $urandom;
            rs2_data      = $urandom;
            ex_alu_result = $urandom;
            mem_rd_addr   = 5'($urandom_range(0, 7));
            mem_rd_wren   = $urandom_range(0, 1) == 1;
            mem_rd_data   = $urandom;
            ex_ready      = ($urandom_range(0, 4) != 0);
            flush         = ($urandom_range(0, 11) == 0);
            tick_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- ID→EX operand stage directly downstream of the register file.
- Drives the regfile read addresses from the decoded instruction and takes the returned rs1_data/rs2_data.
- Resolves RAW hazards by forwarding from the EX and MEM stages. The regfile's own write-through covers WB.
- Detects load-use hazards and inserts a bubble. Registers operands into the ID/EX pipeline register using a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_rd_addr  in  5  destination register index
- id_rd_wren  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- rs1_addr, rs2_addr  out  5  regfile read addresses; combinational copies of id_rs1_addr/id_rs2_addr
- rs1_data, rs2_data  in  XLEN  regfile read data, same cycle
- ex_alu_result  in  XLEN  EX-stage result for the instruction currently held in this block's output register
- mem_rd_addr  in  5  destination of the MEM-stage instruction
- mem_rd_wren  in  1  MEM-stage instruction writes rd
- mem_rd_data  in  XLEN  MEM-stage writeback value
- ex_ready  in  1  EX stage accepts the output register contents
- flush  in  1  synchronous pipeline kill (branch redirect)
- ex_valid  out  1  output register valid
- ex_pc  out  XLEN  registered PC
- ex_rs1_val, ex_rs2_val  out  XLEN  registered forwarded operands
- ex_rd_addr  out  5  registered destination
- ex_rd_wren  out  1  registered write enable
- ex_is_load  out  1  registered load flag
- stall_cnt  out  CNT_W  load-use stall cycle count

Behaviour:
- Reset (asynchronous, rst_ni=0): all ex_* outputs and stall_cnt go to 0 immediately. They hold at 0 until the first clock edge after release.
- Operand select, per source s, with priority:
  - s==0 → 0.
  - Else EX match: ex_valid && ex_rd_wren && !ex_is_load && ex_rd_addr==s → ex_alu_result.
  - Else MEM match: mem_rd_wren && mem_rd_addr==s → mem_rd_data.
  - Else regfile data.
  - When both EX and MEM match, EX wins (younger value).
- Load-use hazard: id_valid && ex_valid && ex_is_load && ex_rd_wren && ex_rd_addr!=0 && ex_rd_addr matches id_rs1_addr or id_rs2_addr.
  - Both sources are checked unconditionally; no per-source use flag.
- id_ready = !hazard && (!ex_valid || ex_ready). Combinational; does not depend on flush.
- Output register update, per rising edge, first matching rule applies:
  1. flush → ex_valid<=0; any ID handshake in this cycle is discarded.
  2. ex_valid && !ex_ready → hold all ex_* outputs.
  3. hazard → ex_valid<=0 (bubble); the load advances to MEM.
  4. Otherwise → ex_valid<=id_valid. When id_valid=1, capture pc, forwarded operands, rd_addr, rd_wren and is_load.
- Latency: 1 cycle from an accepted ID handshake to ex_valid.
- A load-use costs exactly 1 bubble. The next cycle the load's result arrives through the MEM path.
- ex_* data fields are don't-care when ex_valid=0, but hold their last value; no X propagation.
- stall_cnt increments on each clock edge where hazard=1 and flush=0. It saturates at all-ones and never wraps.
- Flush arriving together with a hazard or back-pressure: flush wins; stall_cnt does not increment.
- Reset mid-operation: the in-flight instruction is lost; no partial state remains.

Test Plan:
- Reset, then ID `x1,x2`, regfile returns 0x11/0x22, no matches → next cycle ex_valid=1, ex_rs1_val=0x11, ex_rs2_val=0x22, id_ready=1.
- EX holds ALU op rd=x3 (ex_alu_result=0xAAAA); MEM has rd=x3 with 0xBBBB; ID reads rs1=x3 → ex_rs1_val=0xAAAA. Repeat with no EX match → 0xBBBB.
- EX holds load rd=x5; ID reads rs2=x5:
  - id_ready=0 and the next ex_valid=0.
  - stall_cnt goes 0→1.
  - Next cycle MEM supplies rd=x5 data 0x1234 → ex_rs2_val=0x1234, one bubble only.
- Read x0 while EX/MEM claim a write to x0 with 0xFFFF → ex_rs1_val=0.
- ex_ready=0 for 3 cycles with ex_valid=1 → ex_* outputs stable and id_ready=0. On ex_ready=1 the next instruction is captured.
- flush asserted during a hazard cycle → ex_valid=0 and stall_cnt unchanged.
- rst_ni pulsed low mid-stream → ex_valid and stall_cnt go to 0 immediately, without waiting for a clock edge.
